fwd_scoreboard: RTL and testbench
=================================

// Module: fwd_scoreboard
// PURPOSE
//  Parametrised successor to the EX-stage forwarding unit. Selects each ALU source operand
//  from regfile / EX-MEM / MEM-WB / WB-ID / long-latency completion bus.
//  Adds a registered scoreboard of in-flight multi-cycle writes (div, mul, load) that drives
//  an issue stall. Sits between the ID/EX register and the ALU, next to the div/mul units.
// PARAMETERS
//  XLEN     32  datapath width
//  NSRC     2   source operand ports; port 1 carries the imm/alusrc select
//  REG_AW   5   register index width; NREGS = 2**REG_AW
// PORTS
//  clk              in   1             core clock
//  rst_n            in   1             asynchronous, active-low reset
//  rs_i             in   NSRC x REG_AW ID/EX source register indices
//  rf_data_i        in   NSRC x XLEN   regfile read data
//  exmem_we/_rd/_memread in 1/REG_AW/1  EX-MEM write enable, dest, load flag
//  exmem_data_i     in   XLEN          EX-MEM ALU result
//  exmem_csr_rd_i   in   1             EX-MEM instruction is a CSR read
//  exmem_csr_i      in   XLEN          CSR read value
//  memwb_we/_rd/_data    in 1/REG_AW/XLEN  MEM-WB write-back
//  wbid_we/_rd/_data     in 1/REG_AW/XLEN  WB-ID write-back
//  issue_valid_i    in   1             long-latency op leaves ID/EX this cycle
//  issue_unit_i     in   2             unit_e: DIV, MUL, LOAD
//  issue_rd_i       in   REG_AW        its destination
//  done_valid_i     in   1             long-latency result valid
//  done_rd_i        in   REG_AW        result destination
//  done_data_i      in   XLEN          result value
//  alusrc_i         in   1             port 1 takes imm_i
//  imm_i            in   XLEN          immediate
//  fw_data_o        out  NSRC x XLEN   forwarded operands (pre-imm)
//  op_b_o           out  XLEN          alusrc_i ? imm_i : fw_data_o[1]
//  stall_o          out  1             hold ID/EX, insert bubble
//  pending_o        out  NREGS         scoreboard pending bits
// BEHAVIOUR
//  - Operand select (comb), per port, priority high->low:
//    rs==0 -> rf_data (x0); done bus (valid & rd match); EX-MEM (we & !memread & rd match;
//    exmem_csr_rd_i selects exmem_csr_i, on every port); MEM-WB; WB-ID; rf_data.
//  - Scoreboard: per reg pending bit + unit_e tag, all 0 on reset.
//    Set at clk when issue_valid_i & !stall_o & issue_rd_i!=0; clear when done_valid_i & rd match.
//    Same reg set and clear in one cycle: set wins (younger op). done to non-pending reg: ignored.
//    Visible next cycle; same-cycle completion covered by the done bypass.
//  - stall_o (comb) =
//    any port rs!=0, pending[rs], not bypassed by done bus this cycle
//    | load-use: exmem_memread & exmem_we & exmem_rd==rs!=0
//    | WAW: issue_valid_i & pending[issue_rd_i] & !(done_valid_i & done_rd_i==issue_rd_i).
//  - No flush: pipeline drains long-latency ops. Reset mid-op: pending clears async, late done ignored.
//  - Reset: pending_o=0, counters=0; stall_o reflects only the comb terms.
// CONFIGURATION
//  FWD_PERF_EN defined: adds out ports perf_stall_o, perf_fwd_o (32 b each, saturating).
//    perf_stall_o counts cycles with stall_o=1.
//    perf_fwd_o counts cycles where any port takes a non-regfile source.
//  Undefined: ports and counters absent, zero area.
// STRUCTURE
//  fwd_pkg: fwd_sel_e {SEL_RF, SEL_DONE, SEL_EXMEM, SEL_MEMWB, SEL_WBID}, unit_e {NONE, DIV, MUL, LOAD}.
//  fwd_pkg also holds the scoreboard entry struct.
//  Sub-module fwd_operand_mux: one per port via generate; priority select + data mux.
//  Top holds scoreboard flops, stall logic, perf counters.
// TESTING
//  1 EX-MEM rd=5 data=0x11, MEM-WB rd=5 data=0x22, rs_i[0]=5 -> fw_data_o[0]=0x11.
//  2 rs_i[1]=0, exmem_rd=0 we=1, rf=0 -> fw_data_o[1]=0; alusrc=1 imm=0x7 -> op_b_o=0x7.
//  3 issue DIV rd=8; next cycle rs_i[0]=8 -> stall_o=1 for each cycle until done_valid rd=8.
//  3 (cont.) done cycle: data=0x99, stall_o=0, fw_data_o[0]=0x99; next cycle pending_o[8]=0.
//  4 same cycle issue rd=3 and done rd=3 (already pending) -> pending_o[3] stays 1.
//  5 load in EX-MEM rd=4, rs_i[1]=4 -> stall_o=1; EX-MEM csr_rd=1 rd=6 csr=0xC0 rs_i[1]=6 -> 0xC0.
//  6 rst_n low with 3 pending -> pending_o=0 immediately; FWD_PERF_EN: 10 stall cycles -> perf_stall_o=10.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the operand-forwarding / long-latency scoreboard slice.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package fwd_pkg;

    // Operand source chosen by each forwarding port, in priority order after x0.
    typedef enum logic [2:0] {
        SEL_RF    = 3'd0,
        SEL_DONE  = 3'd1,
        SEL_EXMEM = 3'd2,
        SEL_MEMWB = 3'd3,
        SEL_WBID  = 3'd4
    } fwd_sel_e;

    // Long-latency unit that owns an in-flight destination register.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        DIV  = 2'd1,
        MUL  = 2'd2,
        LOAD = 2'd3
    } unit_e;

    // One scoreboard slot per architectural register.
    typedef struct packed {
        logic  pending;
        unit_e unit;
    } sb_entry_t;

    localparam int PERF_W = 32;

    // Saturating increment used by the event counters.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v,
                                                  input logic              en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// Selects one ALU source operand from regfile, completion bus or a pipeline write-back stage.
// Latency: purely combinational, zero cycles.
// Backpressure: none; stalls are decided by the parent from the same inputs.
module fwd_operand_mux
    import fwd_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [XLEN-1:0]   rf_data_i,
    input  logic              done_valid_i,
    input  logic [REG_AW-1:0] done_rd_i,
    input  logic [XLEN-1:0]   done_data_i,
    input  logic              exmem_we_i,
    input  logic              exmem_memread_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]   exmem_data_i,
    input  logic              exmem_csr_rd_i,
    input  logic [XLEN-1:0]   exmem_csr_i,
    input  logic              memwb_we_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]   memwb_data_i,
    input  logic              wbid_we_i,
    input  logic [REG_AW-1:0] wbid_rd_i,
    input  logic [XLEN-1:0]   wbid_data_i,
    output logic [XLEN-1:0]   data_o,
    output fwd_sel_e          sel_o
);

    // Priority select: x0 never forwards; the completion bus is the newest value for a
    // long-latency destination; a load still in EX-MEM has no data yet and falls through.
    always_comb begin
        sel_o = SEL_RF;
        if (rs_i == '0) begin
            sel_o = SEL_RF;
        end else if (done_valid_i && (done_rd_i == rs_i)) begin
            sel_o = SEL_DONE;
        end else if (exmem_we_i && !exmem_memread_i && (exmem_rd_i == rs_i)) begin
            sel_o = SEL_EXMEM;
        end else if (memwb_we_i && (memwb_rd_i == rs_i)) begin
            sel_o = SEL_MEMWB;
        end else if (wbid_we_i && (wbid_rd_i == rs_i)) begin
            sel_o = SEL_WBID;
        end
    end

    // Data mux driven by the select; a CSR read in EX-MEM carries its value on the CSR path.
    always_comb begin
        data_o = rf_data_i;
        case (sel_o)
            SEL_DONE:  data_o = done_data_i;
            SEL_EXMEM: data_o = exmem_csr_rd_i ? exmem_csr_i : exmem_data_i;
            SEL_MEMWB: data_o = memwb_data_i;
            SEL_WBID:  data_o = wbid_data_i;
            default:   data_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// EX-stage operand forwarding plus a scoreboard of in-flight div/mul/load writes (FWD_PERF_EN adds perf counters).
// Latency: operands and stall are combinational; scoreboard updates are visible one cycle after issue/done.
// Backpressure: stall_o holds ID/EX for pending-source, load-use and WAW hazards; issue is only recorded when not stalled.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NSRC   = 2,
    parameter int REG_AW = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NSRC-1:0][REG_AW-1:0] rs_i,
    input  logic [NSRC-1:0][XLEN-1:0]   rf_data_i,
    input  logic                        exmem_we_i,
    input  logic [REG_AW-1:0]           exmem_rd_i,
    input  logic                        exmem_memread_i,
    input  logic [XLEN-1:0]             exmem_data_i,
    input  logic                        exmem_csr_rd_i,
    input  logic [XLEN-1:0]             exmem_csr_i,
    input  logic                        memwb_we_i,
    input  logic [REG_AW-1:0]           memwb_rd_i,
    input  logic [XLEN-1:0]             memwb_data_i,
    input  logic                        wbid_we_i,
    input  logic [REG_AW-1:0]           wbid_rd_i,
    input  logic [XLEN-1:0]             wbid_data_i,
    input  logic                        issue_valid_i,
    input  unit_e                       issue_unit_i,
    input  logic [REG_AW-1:0]           issue_rd_i,
    input  logic                        done_valid_i,
    input  logic [REG_AW-1:0]           done_rd_i,
    input  logic [XLEN-1:0]             done_data_i,
    input  logic                        alusrc_i,
    input  logic [XLEN-1:0]             imm_i,
    output logic [NSRC-1:0][XLEN-1:0]   fw_data_o,
    output logic [XLEN-1:0]             op_b_o,
    output logic                        stall_o,
    output logic [(2**REG_AW)-1:0]      pending_o
`ifdef FWD_PERF_EN
    ,
    output logic [PERF_W-1:0]           perf_stall_o,
    output logic [PERF_W-1:0]           perf_fwd_o
`endif
);

    localparam int NREGS = 2 ** REG_AW;

    sb_entry_t [NREGS-1:0] sb_q;
    logic [NREGS-1:0]      pending_vec;
    logic [NREGS-1:0]      set_mask;
    logic [NREGS-1:0]      clr_mask;
    logic                  set_en;
    fwd_sel_e [NSRC-1:0]   port_sel;

    // One priority mux per source port.
    for (genvar g = 0; g < NSRC; g++) begin : g_port
        fwd_operand_mux #(
            .XLEN   (XLEN),
            .REG_AW (REG_AW)
        ) u_mux (
            .rs_i            (rs_i[g]),
            .rf_data_i       (rf_data_i[g]),
            .done_valid_i    (done_valid_i),
            .done_rd_i       (done_rd_i),
            .done_data_i     (done_data_i),
            .exmem_we_i      (exmem_we_i),
            .exmem_memread_i (exmem_memread_i),
            .exmem_rd_i      (exmem_rd_i),
            .exmem_data_i    (exmem_data_i),
            .exmem_csr_rd_i  (exmem_csr_rd_i),
            .exmem_csr_i     (exmem_csr_i),
            .memwb_we_i      (memwb_we_i),
            .memwb_rd_i      (memwb_rd_i),
            .memwb_data_i    (memwb_data_i),
            .wbid_we_i       (wbid_we_i),
            .wbid_rd_i       (wbid_rd_i),
            .wbid_data_i     (wbid_data_i),
            .data_o          (fw_data_o[g]),
            .sel_o           (port_sel[g])
        );
    end

    // Port 1 feeds the ALU B input, which may take the immediate instead.
    assign op_b_o = alusrc_i ? imm_i : fw_data_o[1];

    // Flatten the pending bits out of the scoreboard entries.
    always_comb begin
        pending_vec = '0;
        for (int r = 0; r < NREGS; r++) begin
            pending_vec[r] = sb_q[r].pending;
        end
    end

    assign pending_o = pending_vec;

    // Hazard detection: a result arriving on the completion bus this cycle resolves both
    // the source and the WAW hazard because it is bypassed / cleared in the same cycle.
    always_comb begin
        stall_o = 1'b0;
        for (int p = 0; p < NSRC; p++) begin
            if (rs_i[p] != '0) begin
                if (pending_vec[rs_i[p]] && !(done_valid_i && (done_rd_i == rs_i[p]))) begin
                    stall_o = 1'b1;
                end
                if (exmem_memread_i && exmem_we_i && (exmem_rd_i == rs_i[p])) begin
                    stall_o = 1'b1;
                end
            end
        end
        if (issue_valid_i && pending_vec[issue_rd_i]
            && !(done_valid_i && (done_rd_i == issue_rd_i))) begin
            stall_o = 1'b1;
        end
    end

    assign set_en = issue_valid_i && !stall_o && (issue_rd_i != '0);

    // One-hot set/clear requests; a completion only clears a register that is still pending,
    // so a late result after reset (or a stray one) leaves the scoreboard untouched.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) begin
            set_mask[issue_rd_i] = 1'b1;
        end
        if (done_valid_i && pending_vec[done_rd_i]) begin
            clr_mask[done_rd_i] = 1'b1;
        end
    end

    // Scoreboard flops; on a same-register set and clear the younger issue wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (set_mask[r]) begin
                    sb_q[r] <= '{pending: 1'b1, unit: issue_unit_i};
                end else if (clr_mask[r]) begin
                    sb_q[r] <= '{pending: 1'b0, unit: NONE};
                end
            end
        end
    end

    // Unit tags are held for debug visibility; nothing in this block consumes them yet.
    logic sb_tags_unused;
    assign sb_tags_unused = ^sb_q;

`ifdef FWD_PERF_EN
    logic any_fwd;

    // A cycle counts as forwarding when any port takes something other than the regfile.
    always_comb begin
        any_fwd = 1'b0;
        for (int p = 0; p < NSRC; p++) begin
            if (port_sel[p] != SEL_RF) begin
                any_fwd = 1'b1;
            end
        end
    end

    // Saturating stall and forwarding event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_o <= '0;
            perf_fwd_o   <= '0;
        end else begin
            perf_stall_o <= sat_inc(perf_stall_o, stall_o);
            perf_fwd_o   <= sat_inc(perf_fwd_o, any_fwd);
        end
    end
`else
    logic sel_unused;
    assign sel_unused = ^port_sel;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: expectations queued with stimulus, compared at negedge.
// Latency: checks combinational outputs the same cycle, scoreboard state the cycle after.
// Backpressure: n/a (bench drives every input directly).
module tb_fwd_scoreboard;
    import fwd_pkg::*;

    localparam int XLEN   = 32;
    localparam int NSRC   = 2;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NSRC-1:0][REG_AW-1:0] rs;
    logic [NSRC-1:0][XLEN-1:0]   rf_data;
    logic                        exmem_we, exmem_memread, exmem_csr_rd;
    logic [REG_AW-1:0]           exmem_rd;
    logic [XLEN-1:0]             exmem_data, exmem_csr;
    logic                        memwb_we, wbid_we;
    logic [REG_AW-1:0]           memwb_rd, wbid_rd;
    logic [XLEN-1:0]             memwb_data, wbid_data;
    logic                        issue_valid;
    unit_e                       issue_unit;
    logic [REG_AW-1:0]           issue_rd;
    logic                        done_valid;
    logic [REG_AW-1:0]           done_rd;
    logic [XLEN-1:0]             done_data;
    logic                        alusrc;
    logic [XLEN-1:0]             imm;
    logic [NSRC-1:0][XLEN-1:0]   fw_data;
    logic [XLEN-1:0]             op_b;
    logic                        stall;
    logic [NREGS-1:0]            pending;
`ifdef FWD_PERF_EN
    logic [31:0]                 perf_stall, perf_fwd;
`endif

    always #5 clk = ~clk;

    fwd_scoreboard #(.XLEN(XLEN), .NSRC(NSRC), .REG_AW(REG_AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs_i            (rs),
        .rf_data_i       (rf_data),
        .exmem_we_i      (exmem_we),
        .exmem_rd_i      (exmem_rd),
        .exmem_memread_i (exmem_memread),
        .exmem_data_i    (exmem_data),
        .exmem_csr_rd_i  (exmem_csr_rd),
        .exmem_csr_i     (exmem_csr),
        .memwb_we_i      (memwb_we),
        .memwb_rd_i      (memwb_rd),
        .memwb_data_i    (memwb_data),
        .wbid_we_i       (wbid_we),
        .wbid_rd_i       (wbid_rd),
        .wbid_data_i     (wbid_data),
        .issue_valid_i   (issue_valid),
        .issue_unit_i    (issue_unit),
        .issue_rd_i      (issue_rd),
        .done_valid_i    (done_valid),
        .done_rd_i       (done_rd),
        .done_data_i     (done_data),
        .alusrc_i        (alusrc),
        .imm_i           (imm),
        .fw_data_o       (fw_data),
        .op_b_o          (op_b),
        .stall_o         (stall),
        .pending_o       (pending)
`ifdef FWD_PERF_EN
        ,
        .perf_stall_o    (perf_stall),
        .perf_fwd_o      (perf_fwd)
`endif
    );

    typedef enum int {OBS_FW, OBS_OPB, OBS_STALL, OBS_PEND, OBS_PBIT} obs_e;

    string       tag_q[$];
    obs_e        what_q[$];
    int          idx_q[$];
    logic [31:0] val_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input obs_e what, input int idx,
                              input logic [31:0] val);
        tag_q.push_back(tag);
        what_q.push_back(what);
        idx_q.push_back(idx);
        val_q.push_back(val);
    endtask

    function automatic logic [31:0] observe(input obs_e what, input int idx);
        logic [4:0] i5;
        i5 = idx[4:0];
        case (what)
            OBS_FW:    return fw_data[idx[0]];
            OBS_OPB:   return op_b;
            OBS_STALL: return {31'b0, stall};
            OBS_PEND:  return pending;
            default:   return {31'b0, pending[i5]};
        endcase
    endfunction

    task automatic drain();
        while (tag_q.size() > 0) begin
            check_val(tag_q.pop_front(), observe(what_q.pop_front(), idx_q.pop_front()),
                      val_q.pop_front());
        end
    endtask

    task automatic step();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rs = '0; rf_data[0] = 32'hA0; rf_data[1] = 32'hB1;
        exmem_we = 0; exmem_memread = 0; exmem_csr_rd = 0; exmem_rd = '0;
        exmem_data = '0; exmem_csr = '0;
        memwb_we = 0; memwb_rd = '0; memwb_data = '0;
        wbid_we = 0; wbid_rd = '0; wbid_data = '0;
        issue_valid = 0; issue_unit = NONE; issue_rd = '0;
        done_valid = 0; done_rd = '0; done_data = '0;
        alusrc = 0; imm = '0;
    endtask

    // Independent reference for the operand priority (no scoreboard involvement).
    function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return rf;
        if (done_valid && done_rd == r) return done_data;
        if (exmem_we && !exmem_memread && exmem_rd == r) return exmem_csr_rd ? exmem_csr : exmem_data;
        if (memwb_we && memwb_rd == r) return memwb_data;
        if (wbid_we && wbid_rd == r) return wbid_data;
        return rf;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] e0, e1;
        logic        es;
        set_idle();
        rst_n = 0;
        expect_out("rst_pending", OBS_PEND, 0, 32'h0);
        expect_out("rst_stall", OBS_STALL, 0, 32'h0);
        step();
        rst_n = 1;

        // Forwarding priority on port 0
        set_idle(); rs[0] = 5;
        exmem_we = 1; exmem_rd = 5; exmem_data = 32'h11;
        memwb_we = 1; memwb_rd = 5; memwb_data = 32'h22;
        expect_out("t1_exmem", OBS_FW, 0, 32'h11); step();
        exmem_we = 0;
        expect_out("t1_memwb", OBS_FW, 0, 32'h22); step();
        memwb_we = 0; wbid_we = 1; wbid_rd = 5; wbid_data = 32'h33;
        expect_out("t1_wbid", OBS_FW, 0, 32'h33); step();
        wbid_we = 0;
        expect_out("t1_rf", OBS_FW, 0, 32'hA0); step();
        exmem_we = 1; exmem_memread = 1; memwb_we = 1;
        expect_out("t1_load_skip", OBS_FW, 0, 32'h22);
        expect_out("t1_load_stall", OBS_STALL, 0, 32'h1); step();

        // x0 and immediate select
        set_idle(); rf_data[1] = 0; exmem_we = 1; exmem_rd = 0; exmem_data = 32'h55;
        alusrc = 1; imm = 32'h7;
        expect_out("t2_x0_p1", OBS_FW, 1, 32'h0);
        expect_out("t2_x0_p0", OBS_FW, 0, 32'hA0);
        expect_out("t2_imm", OBS_OPB, 0, 32'h7); step();
        alusrc = 0; rs[1] = 2; exmem_rd = 2;
        expect_out("t2_opb_fw", OBS_OPB, 0, 32'h55); step();

        // Load-use stall, CSR forwarding, done-bus priority
        set_idle(); exmem_we = 1; exmem_memread = 1; exmem_rd = 4; rs[1] = 4;
        expect_out("t5_loaduse", OBS_STALL, 0, 32'h1); step();
        set_idle(); exmem_we = 1; exmem_rd = 6; exmem_csr_rd = 1; exmem_csr = 32'hC0;
        exmem_data = 32'h123; rs[0] = 6; rs[1] = 6;
        expect_out("t5_csr_p0", OBS_FW, 0, 32'hC0);
        expect_out("t5_csr_p1", OBS_FW, 1, 32'hC0);
        expect_out("t5_csr_nostall", OBS_STALL, 0, 32'h0); step();
        set_idle(); done_valid = 1; done_rd = 5; done_data = 32'h77;
        exmem_we = 1; exmem_rd = 5; exmem_data = 32'h11; rs[0] = 5;
        expect_out("t5_done_prio", OBS_FW, 0, 32'h77); step();
        set_idle();
        expect_out("t5_stray_done", OBS_PEND, 0, 32'h0); step();

        // Randomised operand select with nothing pending
        for (int k = 0; k < 24; k++) begin
            set_idle();
            rs[0] = 5'($urandom_range(0, 3)); rs[1] = 5'($urandom_range(0, 3));
            rf_data[0] = $urandom; rf_data[1] = $urandom;
            done_valid = 1'($urandom); done_rd = 5'($urandom_range(0, 3)); done_data = $urandom;
            exmem_we = 1'($urandom); exmem_memread = 1'($urandom); exmem_csr_rd = 1'($urandom);
            exmem_rd = 5'($urandom_range(0, 3)); exmem_data = $urandom; exmem_csr = $urandom;
            memwb_we = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_data = $urandom;
            wbid_we = 1'($urandom); wbid_rd = 5'($urandom_range(0, 3)); wbid_data = $urandom;
            alusrc = 1'($urandom); imm = $urandom;
            e0 = model_fwd(rs[0], rf_data[0]);
            e1 = model_fwd(rs[1], rf_data[1]);
            es = 0;
            for (int p = 0; p < NSRC; p++)
                if (rs[p] != 0 && exmem_memread && exmem_we && exmem_rd == rs[p]) es = 1;
            expect_out("rnd_fw0", OBS_FW, 0, e0);
            expect_out("rnd_fw1", OBS_FW, 1, e1);
            expect_out("rnd_opb", OBS_OPB, 0, alusrc ? imm : e1);
            expect_out("rnd_stall", OBS_STALL, 0, {31'b0, es});
            step();
        end

        // DIV issue, pending-source stall, completion bypass and clear
        set_idle(); issue_valid = 1; issue_unit = DIV; issue_rd = 8;
        expect_out("t3_issue_nostall", OBS_STALL, 0, 32'h0); step();
        set_idle(); rs[0] = 8;
        for (int k = 0; k < 3; k++) begin
            expect_out("t3_wait_stall", OBS_STALL, 0, 32'h1);
            expect_out("t3_pend8", OBS_PBIT, 8, 32'h1);
            step();
        end
        done_valid = 1; done_rd = 8; done_data = 32'h99;
        expect_out("t3_done_stall", OBS_STALL, 0, 32'h0);
        expect_out("t3_done_data", OBS_FW, 0, 32'h99); step();
        set_idle(); rs[0] = 8;
        expect_out("t3_cleared", OBS_PBIT, 8, 32'h0);
        expect_out("t3_after_stall", OBS_STALL, 0, 32'h0);
        expect_out("t3_after_rf", OBS_FW, 0, 32'hA0); step();

        // WAW, same-cycle set/clear, stalled issue, issue to x0, stray done
        set_idle(); issue_valid = 1; issue_unit = MUL; issue_rd = 3; step();
        set_idle(); issue_valid = 1; issue_unit = MUL; issue_rd = 3;
        expect_out("t4_waw", OBS_STALL, 0, 32'h1); step();
        done_valid = 1; done_rd = 3; done_data = 32'h44;
        expect_out("t4_waw_bypass", OBS_STALL, 0, 32'h0); step();
        set_idle();
        expect_out("t4_set_wins", OBS_PBIT, 3, 32'h1);
        expect_out("t4_pend_vec", OBS_PEND, 0, 32'h8); step();
        set_idle(); rs[0] = 3; issue_valid = 1; issue_unit = DIV; issue_rd = 9;
        expect_out("t4_issue_stalled", OBS_STALL, 0, 32'h1); step();
        set_idle();
        expect_out("t4_no_set_on_stall", OBS_PEND, 0, 32'h8); step();
        set_idle(); issue_valid = 1; issue_unit = DIV; issue_rd = 0;
        done_valid = 1; done_rd = 12; step();
        set_idle();
        expect_out("t4_x0_stray", OBS_PEND, 0, 32'h8); step();

        // Asynchronous reset with three registers pending; late completion ignored
        set_idle(); issue_valid = 1; issue_unit = LOAD; issue_rd = 10; step();
        issue_rd = 11; step();
        set_idle();
        expect_out("t6_three_pending", OBS_PEND, 0, 32'h0000_0C08); step();
        #2; rst_n = 0; #1;
        expect_out("t6_async_clear", OBS_PEND, 0, 32'h0);
        drain();
        @(posedge clk); #1; rst_n = 1;
        set_idle(); done_valid = 1; done_rd = 10; done_data = 32'h5; step();
        set_idle();
        expect_out("t6_late_done", OBS_PEND, 0, 32'h0); step();

`ifdef FWD_PERF_EN
        check_val("perf_stall_idle", perf_stall, 32'd0);
        set_idle(); exmem_we = 1; exmem_memread = 1; exmem_rd = 4; rs[1] = 4;
        repeat (10) @(posedge clk);
        #1; set_idle();
        check_val("perf_stall_10", perf_stall, 32'd10);
        check_val("perf_fwd_0", perf_fwd, 32'd0);
        rs[0] = 5; exmem_we = 1; exmem_rd = 5; exmem_data = 32'h1;
        repeat (3) @(posedge clk);
        #1; set_idle();
        check_val("perf_fwd_3", perf_fwd, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
